// File: rtl/bp_fe_pkg.sv
// Shared types for the FE predictor-update scheduler.
package bp_fe_pkg;

  localparam int unsigned upd_width_gp = 64;

  typedef enum logic {
    e_idle,
    e_issue
  } bp_fe_sched_state_e;

  typedef enum logic {
    e_src_redirect,
    e_src_attaboy
  } bp_fe_sched_src_e;

  typedef struct packed {
    logic                    btb;
    logic                    bht;
    logic [upd_width_gp-1:0] pkt;
  } bp_fe_upd_s;

endpackage

// File: rtl/bsg_fifo_1r1w_small.sv
// Small 1-read/1-write FIFO with wrap-bit pointers; reset_i is synchronous, active-low.
module bsg_fifo_1r1w_small #(
  parameter int unsigned width_p = 8,
  parameter int unsigned els_p   = 4
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               v_i,
  output logic               ready_o,
  input  logic [width_p-1:0] data_i,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               yumi_i
);

  localparam int unsigned ptr_w_lp = $clog2(els_p);

  logic [ptr_w_lp:0]  wptr_r, rptr_r;
  logic [width_p-1:0] mem_r [els_p];
  logic               empty, full, enq, deq;

  assign empty   = (wptr_r == rptr_r);
  assign full    = (wptr_r[ptr_w_lp] != rptr_r[ptr_w_lp])
                && (wptr_r[ptr_w_lp-1:0] == rptr_r[ptr_w_lp-1:0]);
  assign ready_o = ~full;
  assign v_o     = ~empty;
  assign data_o  = mem_r[rptr_r[ptr_w_lp-1:0]];
  // A full FIFO may still take a write when the head leaves in the same cycle.
  assign enq     = v_i & (~full | yumi_i);
  assign deq     = yumi_i & ~empty;

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      wptr_r <= '0;
      rptr_r <= '0;
    end else begin
      if (enq) wptr_r <= wptr_r + (ptr_w_lp+1)'(1);
      if (deq) rptr_r <= rptr_r + (ptr_w_lp+1)'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (enq) mem_r[wptr_r[ptr_w_lp-1:0]] <= data_i;
  end

endmodule

// File: rtl/bp_fe_pred_update_sched.sv
// Schedules redirect and attaboy predictor-training writes onto the BTB/BHT write ports.
module bp_fe_pred_update_sched
  import bp_fe_pkg::*;
#(
  parameter int unsigned upd_width_p      = upd_width_gp,
  parameter int unsigned ab_els_p         = 4,
  parameter int unsigned starve_limit_p   = 3,
  parameter int unsigned drop_cnt_width_p = 8
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic                        init_done_i,
  input  logic                        redirect_v_i,
  input  logic                        redirect_btb_i,
  input  logic                        redirect_bht_i,
  input  logic [upd_width_p-1:0]      redirect_pkt_i,
  input  logic                        attaboy_v_i,
  input  logic                        attaboy_btb_i,
  input  logic                        attaboy_bht_i,
  input  logic [upd_width_p-1:0]      attaboy_pkt_i,
  output logic                        attaboy_yumi_o,
  output logic                        btb_w_v_o,
  output logic [upd_width_p-1:0]      btb_w_pkt_o,
  input  logic                        btb_w_yumi_i,
  output logic                        bht_w_v_o,
  output logic [upd_width_p-1:0]      bht_w_pkt_o,
  input  logic                        bht_w_yumi_i,
  output logic                        busy_o,
  output logic [drop_cnt_width_p-1:0] drop_cnt_o
);

  localparam int unsigned starve_w_lp = $clog2(starve_limit_p + 1);
  localparam int unsigned fifo_w_lp   = $bits(bp_fe_upd_s);

  bp_fe_sched_state_e state_r, state_n;
  bp_fe_sched_src_e   src_r, sel_src;
  bp_fe_upd_s         slot_r, shadow_r, ab_head, ab_in, rd_in, sel_entry;
  logic               slot_v_r, shadow_v_r;
  logic               need_btb_r, need_bht_r, btb_done_r, bht_done_r;
  logic [starve_w_lp-1:0]      starve_r;
  logic [drop_cnt_width_p-1:0] drop_cnt_r;
  logic [fifo_w_lp-1:0]        ab_head_raw;
  logic ab_ready, ab_v, ab_enq, ab_deq;
  logic starve_ok, cand_rd, sel_v, need_btb, need_bht;
  logic btb_v, bht_v, btb_hs, bht_hs, retire, rd_lock, rd_new, drop_inc;

  assign ab_in   = '{btb: attaboy_btb_i, bht: attaboy_bht_i, pkt: upd_width_gp'(attaboy_pkt_i)};
  assign rd_in   = '{btb: redirect_btb_i, bht: redirect_bht_i, pkt: upd_width_gp'(redirect_pkt_i)};
  assign ab_head = bp_fe_upd_s'(ab_head_raw);

  bsg_fifo_1r1w_small #(
    .width_p(fifo_w_lp),
    .els_p  (ab_els_p)
  ) ab_fifo (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .v_i    (ab_enq),
    .ready_o(ab_ready),
    .data_i (ab_in),
    .v_o    (ab_v),
    .data_o (ab_head_raw),
    .yumi_i (ab_deq)
  );

  // Entry selection (locked once in ISSUE), handshakes and retirement.
  always_comb begin
    starve_ok = (starve_r < starve_w_lp'(starve_limit_p));
    cand_rd   = slot_v_r & (starve_ok | ~ab_v);
    sel_v     = 1'b0;
    sel_src   = e_src_attaboy;
    if (state_r == e_issue) begin
      sel_v   = 1'b1;
      sel_src = src_r;
    end else if (init_done_i & (slot_v_r | ab_v)) begin
      sel_v   = 1'b1;
      sel_src = cand_rd ? e_src_redirect : e_src_attaboy;
    end
    sel_entry = (sel_src == e_src_redirect) ? slot_r : ab_head;
    need_btb  = (state_r == e_issue) ? need_btb_r : sel_entry.btb;
    need_bht  = (state_r == e_issue) ? need_bht_r : sel_entry.bht;
    btb_v     = sel_v & need_btb & ~btb_done_r;
    bht_v     = sel_v & need_bht & ~bht_done_r;
    btb_hs    = btb_v & btb_w_yumi_i;
    bht_hs    = bht_v & bht_w_yumi_i;
    retire    = sel_v & (~need_btb | btb_done_r | btb_hs) & (~need_bht | bht_done_r | bht_hs);
    rd_lock   = sel_v & (sel_src == e_src_redirect);
    rd_new    = redirect_v_i & (redirect_btb_i | redirect_bht_i);
    drop_inc  = rd_new & ~(retire & rd_lock) & (rd_lock ? shadow_v_r : slot_v_r);
    ab_deq    = retire & (sel_src == e_src_attaboy);
    ab_enq    = attaboy_v_i & ab_ready & (attaboy_btb_i | attaboy_bht_i);
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) state_r <= e_idle;
    else          state_r <= state_n;
  end

  always_comb begin
    state_n = state_r;
    case (state_r)
      e_idle:  if (sel_v & ~retire) state_n = e_issue;
      e_issue: if (retire)          state_n = e_idle;
      default: state_n = e_idle;
    endcase
  end

  always_comb begin
    attaboy_yumi_o = 1'b0;
    btb_w_v_o      = 1'b0;
    bht_w_v_o      = 1'b0;
    btb_w_pkt_o    = '0;
    bht_w_pkt_o    = '0;
    busy_o         = 1'b0;
    drop_cnt_o     = '0;
    if (reset_i) begin
      attaboy_yumi_o = attaboy_v_i & ab_ready;
      btb_w_v_o      = btb_v;
      bht_w_v_o      = bht_v;
      btb_w_pkt_o    = upd_width_p'(sel_entry.pkt);
      bht_w_pkt_o    = upd_width_p'(sel_entry.pkt);
      busy_o         = slot_v_r | shadow_v_r | ab_v | (state_r == e_issue);
      drop_cnt_o     = drop_cnt_r;
    end
  end

  // Latched selection, done bits, starvation and drop accounting.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      src_r      <= e_src_redirect;
      need_btb_r <= 1'b0;
      need_bht_r <= 1'b0;
      btb_done_r <= 1'b0;
      bht_done_r <= 1'b0;
      starve_r   <= '0;
      drop_cnt_r <= '0;
    end else begin
      if ((state_r == e_idle) & sel_v) begin
        src_r      <= sel_src;
        need_btb_r <= sel_entry.btb;
        need_bht_r <= sel_entry.bht;
      end
      btb_done_r <= ~retire & (btb_done_r | btb_hs);
      bht_done_r <= ~retire & (bht_done_r | bht_hs);
      if (ab_deq | ~ab_v)
        starve_r <= '0;
      else if (retire & rd_lock & starve_ok)
        starve_r <= starve_r + starve_w_lp'(1);
      if (drop_inc & (drop_cnt_r != '1))
        drop_cnt_r <= drop_cnt_r + drop_cnt_width_p'(1);
    end
  end

  // Redirect slot plus shadow for arrivals while the slot entry is in flight.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      slot_v_r   <= 1'b0;
      shadow_v_r <= 1'b0;
      slot_r     <= '0;
      shadow_r   <= '0;
    end else if (retire & rd_lock) begin
      if (shadow_v_r) begin
        slot_r     <= shadow_r;
        shadow_v_r <= rd_new;
        shadow_r   <= rd_in;
      end else begin
        slot_v_r <= rd_new;
        slot_r   <= rd_in;
      end
    end else if (rd_new) begin
      if (rd_lock) begin
        shadow_v_r <= 1'b1;
        shadow_r   <= rd_in;
      end else begin
        slot_v_r <= 1'b1;
        slot_r   <= rd_in;
      end
    end
  end

endmodule

// File: tb/tb_bp_fe_pred_update_sched.sv
// Bench for bp_fe_pred_update_sched: queue-based reference model checked every cycle plus directed scenarios.
module tb_bp_fe_pred_update_sched;

  typedef struct packed {
    logic        btb;
    logic        bht;
    logic [63:0] pkt;
  } upd_t;

  logic        clk = 1'b0;
  logic        reset_i = 1'b0;
  logic        init_done_i = 1'b1;
  logic        redirect_v_i = 1'b0, redirect_btb_i = 1'b0, redirect_bht_i = 1'b0;
  logic [63:0] redirect_pkt_i = '0;
  logic        attaboy_v_i = 1'b0, attaboy_btb_i = 1'b0, attaboy_bht_i = 1'b0;
  logic [63:0] attaboy_pkt_i = '0;
  logic        attaboy_yumi_o;
  logic        btb_w_v_o, bht_w_v_o;
  logic [63:0] btb_w_pkt_o, bht_w_pkt_o;
  logic        btb_w_yumi_i = 1'b0, bht_w_yumi_i = 1'b0;
  logic        busy_o;
  logic [7:0]  drop_cnt_o;

  int n_cmp = 0;
  int n_err = 0;

  bp_fe_pred_update_sched dut (
    .clk_i         (clk),
    .reset_i       (reset_i),
    .init_done_i   (init_done_i),
    .redirect_v_i  (redirect_v_i),
    .redirect_btb_i(redirect_btb_i),
    .redirect_bht_i(redirect_bht_i),
    .redirect_pkt_i(redirect_pkt_i),
    .attaboy_v_i   (attaboy_v_i),
    .attaboy_btb_i (attaboy_btb_i),
    .attaboy_bht_i (attaboy_bht_i),
    .attaboy_pkt_i (attaboy_pkt_i),
    .attaboy_yumi_o(attaboy_yumi_o),
    .btb_w_v_o     (btb_w_v_o),
    .btb_w_pkt_o   (btb_w_pkt_o),
    .btb_w_yumi_i  (btb_w_yumi_i),
    .bht_w_v_o     (bht_w_v_o),
    .bht_w_pkt_o   (bht_w_pkt_o),
    .bht_w_yumi_i  (bht_w_yumi_i),
    .busy_o        (busy_o),
    .drop_cnt_o    (drop_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: redirect list (slot then shadow), attaboy queue, one in-progress entry.
  upd_t ab_q[$];
  upd_t rd_q[$];
  bit   act, act_rd, need_b, need_h, done_b, done_h;
  int   starve, drops;

  always @(negedge clk) begin : model_cmp
    bit cur, cur_rd, nb, nh, db, dh, hs_b, hs_h, fin, e_bv, e_hv, e_yumi, e_busy, rd_in;
    logic [63:0] e_pkt;
    upd_t head, nw;
    if (!reset_i) begin
      check("rst_yumi", attaboy_yumi_o, 0);
      check("rst_btb_v", btb_w_v_o, 0);
      check("rst_bht_v", bht_w_v_o, 0);
      check("rst_btb_pkt", btb_w_pkt_o, 0);
      check("rst_bht_pkt", bht_w_pkt_o, 0);
      check("rst_busy", busy_o, 0);
      check("rst_drop", drop_cnt_o, 0);
      ab_q.delete();
      rd_q.delete();
      act = 0; done_b = 0; done_h = 0; starve = 0; drops = 0;
    end else begin
      cur = 0; cur_rd = 0; nb = 0; nh = 0; db = 0; dh = 0; e_pkt = '0;
      if (act) begin
        cur = 1; cur_rd = act_rd; nb = need_b; nh = need_h; db = done_b; dh = done_h;
      end else if (init_done_i && (rd_q.size() != 0 || ab_q.size() != 0)) begin
        cur = 1;
        cur_rd = (rd_q.size() != 0) && (starve < 3 || ab_q.size() == 0);
        head = cur_rd ? rd_q[0] : ab_q[0];
        nb = head.btb; nh = head.bht;
      end
      if (cur) e_pkt = cur_rd ? rd_q[0].pkt : ab_q[0].pkt;
      e_bv   = cur && nb && !db;
      e_hv   = cur && nh && !dh;
      e_yumi = attaboy_v_i && (ab_q.size() < 4);
      e_busy = act || (rd_q.size() != 0) || (ab_q.size() != 0);
      check("yumi", attaboy_yumi_o, e_yumi);
      check("btb_v", btb_w_v_o, e_bv);
      check("bht_v", bht_w_v_o, e_hv);
      if (e_bv) check("btb_pkt", btb_w_pkt_o, e_pkt);
      if (e_hv) check("bht_pkt", bht_w_pkt_o, e_pkt);
      check("busy", busy_o, e_busy);
      check("drop_cnt", drop_cnt_o, 64'(drops));

      hs_b = e_bv && btb_w_yumi_i;
      hs_h = e_hv && bht_w_yumi_i;
      fin  = cur && (!nb || db || hs_b) && (!nh || dh || hs_h);

      if (ab_q.size() == 0 || (fin && !cur_rd)) starve = 0;
      else if (fin && cur_rd && starve < 3) starve++;

      nw.btb = redirect_btb_i; nw.bht = redirect_bht_i; nw.pkt = redirect_pkt_i;
      rd_in = redirect_v_i && (redirect_btb_i || redirect_bht_i);
      if (fin && cur_rd) begin
        void'(rd_q.pop_front());
        if (rd_in) rd_q.push_back(nw);
      end else if (rd_in) begin
        if (cur && cur_rd) begin
          if (rd_q.size() == 2) begin
            rd_q[1] = nw;
            if (drops < 255) drops++;
          end else rd_q.push_back(nw);
        end else if (rd_q.size() != 0) begin
          rd_q[0] = nw;
          if (drops < 255) drops++;
        end else rd_q.push_back(nw);
      end

      if (fin && !cur_rd) void'(ab_q.pop_front());
      if (e_yumi && (attaboy_btb_i || attaboy_bht_i)) begin
        nw.btb = attaboy_btb_i; nw.bht = attaboy_bht_i; nw.pkt = attaboy_pkt_i;
        ab_q.push_back(nw);
      end

      if (cur && !fin) begin
        act = 1; act_rd = cur_rd; need_b = nb; need_h = nh;
        done_b = db || hs_b; done_h = dh || hs_h;
      end else begin
        act = 0; done_b = 0; done_h = 0;
      end
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 reset_i = 1'b1;
    check("post_rst_busy", busy_o, 0);

    // Dual-target redirect, BTB accepted two cycles before BHT.
    tick(); redirect_v_i = 1; redirect_btb_i = 1; redirect_bht_i = 1; redirect_pkt_i = 64'hA5;
    #1 check("s1_pre_btb_v", btb_w_v_o, 0);
    tick(); redirect_v_i = 0; btb_w_yumi_i = 1;
    #1 check("s1_btb_v", btb_w_v_o, 1); check("s1_bht_v", bht_w_v_o, 1);
    check("s1_btb_pkt", btb_w_pkt_o, 64'hA5);
    tick(); btb_w_yumi_i = 0;
    #1 check("s1_btb_drop", btb_w_v_o, 0); check("s1_bht_hold", bht_w_v_o, 1);
    check("s1_bht_pkt", bht_w_pkt_o, 64'hA5);
    tick(); bht_w_yumi_i = 1;
    #1 check("s1_bht_v2", bht_w_v_o, 1);
    tick(); bht_w_yumi_i = 0;
    #1 check("s1_busy_done", busy_o, 0); check("s1_bht_off", bht_w_v_o, 0);

    // Five attaboys against a stalled BTB: the fifth waits for the first retire.
    for (int i = 0; i < 4; i++) begin
      tick(); attaboy_v_i = 1; attaboy_btb_i = 1; attaboy_bht_i = 0; attaboy_pkt_i = 64'h100 + 64'(i);
      #1 check("s2_yumi", attaboy_yumi_o, 1);
    end
    tick(); attaboy_pkt_i = 64'h104;
    #1 check("s2_full_yumi", attaboy_yumi_o, 0);
    tick(); btb_w_yumi_i = 1;
    #1 check("s2_full_yumi2", attaboy_yumi_o, 0); check("s2_head_pkt", btb_w_pkt_o, 64'h100);
    tick(); btb_w_yumi_i = 0;
    #1 check("s2_freed_yumi", attaboy_yumi_o, 1);
    tick(); attaboy_v_i = 0; btb_w_yumi_i = 1;
    for (int k = 0; k < 12 && busy_o; k++) tick();
    btb_w_yumi_i = 0;
    #1 check("s2_drained", busy_o, 0);

    // Attaboy half written, then a redirect: attaboy finishes, redirect follows with no gap.
    tick(); attaboy_v_i = 1; attaboy_btb_i = 1; attaboy_bht_i = 1; attaboy_pkt_i = 64'h300;
    tick(); attaboy_v_i = 0; btb_w_yumi_i = 1;
    tick(); btb_w_yumi_i = 0; redirect_v_i = 1; redirect_btb_i = 1; redirect_bht_i = 0; redirect_pkt_i = 64'h301;
    #1 check("s3_bht_pkt", bht_w_pkt_o, 64'h300); check("s3_btb_v", btb_w_v_o, 0);
    tick(); redirect_v_i = 0; bht_w_yumi_i = 1;
    #1 check("s3_locked_pkt", bht_w_pkt_o, 64'h300); check("s3_no_preempt", btb_w_v_o, 0);
    tick(); bht_w_yumi_i = 0; btb_w_yumi_i = 1;
    #1 check("s3_rd_btb_v", btb_w_v_o, 1); check("s3_rd_pkt", btb_w_pkt_o, 64'h301);
    tick(); btb_w_yumi_i = 0;
    #1 check("s3_busy_done", busy_o, 0);

    // Two redirects while tables are not ready: only the second survives.
    init_done_i = 0;
    tick(); redirect_v_i = 1; redirect_btb_i = 1; redirect_bht_i = 0; redirect_pkt_i = 64'h11;
    tick(); redirect_pkt_i = 64'h22;
    #1 check("s4_drop0", drop_cnt_o, 0);
    tick(); redirect_v_i = 0;
    #1 check("s4_drop1", drop_cnt_o, 1); check("s4_no_issue", btb_w_v_o, 0); check("s4_busy", busy_o, 1);
    tick(); init_done_i = 1; btb_w_yumi_i = 1;
    #1 check("s4_btb_v", btb_w_v_o, 1); check("s4_pkt", btb_w_pkt_o, 64'h22);
    tick(); btb_w_yumi_i = 0;
    #1 check("s4_idle", busy_o, 0); check("s4_drop_keep", drop_cnt_o, 1);

    // Reset while an attaboy is in flight with three entries queued.
    for (int i = 0; i < 3; i++) begin
      tick(); attaboy_v_i = 1; attaboy_btb_i = 1; attaboy_bht_i = 0; attaboy_pkt_i = 64'h500 + 64'(i);
    end
    tick(); attaboy_v_i = 0;
    #1 check("s5_issue", btb_w_v_o, 1); check("s5_busy", busy_o, 1);
    tick(); reset_i = 0; attaboy_v_i = 1;
    #1 check("s5_rst_yumi", attaboy_yumi_o, 0); check("s5_rst_btb", btb_w_v_o, 0);
    tick(); reset_i = 1; attaboy_v_i = 0;
    #1 check("s5_btb_v", btb_w_v_o, 0); check("s5_bht_v", bht_w_v_o, 0);
    check("s5_busy", busy_o, 0); check("s5_drop", drop_cnt_o, 0);

    // Randomised traffic checked by the model every cycle.
    for (int c = 0; c < 4000; c++) begin
      tick();
      reset_i        = ($urandom_range(0, 499) != 0);
      init_done_i    = ($urandom_range(0, 9) != 0);
      redirect_v_i   = ($urandom_range(0, 99) < 18);
      redirect_btb_i = $urandom_range(0, 1) != 0;
      redirect_bht_i = $urandom_range(0, 1) != 0;
      redirect_pkt_i = {$urandom, $urandom};
      attaboy_v_i    = ($urandom_range(0, 99) < 40);
      attaboy_btb_i  = $urandom_range(0, 1) != 0;
      attaboy_bht_i  = $urandom_range(0, 1) != 0;
      attaboy_pkt_i  = {$urandom, $urandom};
      btb_w_yumi_i   = ($urandom_range(0, 99) < 55);
      bht_w_yumi_i   = ($urandom_range(0, 99) < 55);
    end
    tick();
    reset_i = 1; redirect_v_i = 0; attaboy_v_i = 0;
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
